// File: rtl/source_arbiter.sv
// Two-source packet arbiter: round-robin grant, BURST_LEN bytes per packet, registered outputs.
// Define SRC_ARB_TIMEOUT_EN to add the idle-abort timer and the timeout output.
module source_arbiter #(
  parameter int unsigned BURST_LEN = 512,
  parameter int unsigned IDLE_TO   = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic en1,
  input  logic en2,
  output logic gnt1,
  output logic gnt2,
  output logic flag,
  output logic busy,
  output logic pkt_done
`ifdef SRC_ARB_TIMEOUT_EN
  ,
  output logic timeout
`endif
);

  localparam int unsigned CW = $clog2(BURST_LEN);
  localparam int unsigned IW = $clog2(IDLE_TO + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BURST_LEN - 1);

  if (BURST_LEN < 2 || BURST_LEN > 65535) begin : g_bad_burst_len
    $error("source_arbiter: BURST_LEN out of range");
  end
  if (IDLE_TO < 1 || IDLE_TO > 65535) begin : g_bad_idle_to
    $error("source_arbiter: IDLE_TO out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          last_src, last_src_n;   // 1 = source 2 was granted last
  logic          flag_n;
  logic          done_n;
  logic          byte_ok;

`ifdef SRC_ARB_TIMEOUT_EN
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic          timeout_n;
`endif

  always_comb begin
    state_n    = state;
    count_n    = count;
    last_src_n = last_src;
    flag_n     = flag;
    done_n     = 1'b0;
    byte_ok    = 1'b0;
`ifdef SRC_ARB_TIMEOUT_EN
    idle_cnt_n = idle_cnt;
    timeout_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef SRC_ARB_TIMEOUT_EN
        idle_cnt_n = '0;
`endif
        if (req1 && (!req2 || last_src)) begin
          state_n    = GRANT1;
          flag_n     = 1'b0;
          last_src_n = 1'b0;
        end else if (req2) begin
          state_n    = GRANT2;
          flag_n     = 1'b1;
          last_src_n = 1'b1;
        end
      end
      GRANT1, GRANT2: begin
        byte_ok = (state == GRANT1) ? en1 : en2;
        if (byte_ok) begin
`ifdef SRC_ARB_TIMEOUT_EN
          idle_cnt_n = '0;
`endif
          if (count == LAST_BYTE) begin
            state_n = GAP;
            count_n = '0;
            done_n  = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
`ifdef SRC_ARB_TIMEOUT_EN
        // abort on the edge that would complete the IDLE_TO-th idle cycle
        else if (idle_cnt == IW'(IDLE_TO - 1)) begin
          state_n    = GAP;
          count_n    = '0;
          idle_cnt_n = '0;
          timeout_n  = 1'b1;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
`endif
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      last_src <= 1'b1;
      gnt1     <= 1'b0;
      gnt2     <= 1'b0;
      flag     <= 1'b0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
`ifdef SRC_ARB_TIMEOUT_EN
      idle_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      last_src <= last_src_n;
      gnt1     <= (state_n == GRANT1);
      gnt2     <= (state_n == GRANT2);
      flag     <= flag_n;
      busy     <= (state_n != IDLE);
      pkt_done <= done_n;
`ifdef SRC_ARB_TIMEOUT_EN
      idle_cnt <= idle_cnt_n;
      timeout  <= timeout_n;
`endif
    end
  end

endmodule

// File: tb/tb_source_arbiter.sv
// Directed bench for source_arbiter with BURST_LEN=4, IDLE_TO=3; covers both SRC_ARB_TIMEOUT_EN builds.
module tb_source_arbiter;

  logic clk = 1'b0;
  logic rst, req1, req2, en1, en2;
  logic gnt1, gnt2, flag, busy, pkt_done;
`ifdef SRC_ARB_TIMEOUT_EN
  logic timeout;
`endif

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  source_arbiter #(
    .BURST_LEN(4),
    .IDLE_TO  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req1    (req1),
    .req2    (req2),
    .en1     (en1),
    .en2     (en2),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .flag    (flag),
    .busy    (busy),
    .pkt_done(pkt_done)
`ifdef SRC_ARB_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants are exclusive; flag may only move on the cycle a grant is entered.
  logic pg1 = 1'b0, pg2 = 1'b0, pflag = 1'b0, prst = 1'b1;
  always @(negedge clk) begin
    if (!rst && !prst) begin
      check("mutex", {31'b0, gnt1 & gnt2}, 32'd0);
      if (flag !== pflag)
        check("flag_entry", {31'b0, (gnt1 && !pg1 && !flag) || (gnt2 && !pg2 && flag)}, 32'd1);
    end
    pg1   <= gnt1;
    pg2   <= gnt2;
    pflag <= flag;
    prst  <= rst;
  end

  task automatic wait_grant(input int exp);
    int n = 0;
    while (!gnt1 && !gnt2 && n < 10) begin
      tick();
      n++;
    end
    check("grant_src", gnt1 ? 1 : (gnt2 ? 2 : 0), exp);
    check("grant_flag", {31'b0, flag}, exp - 1);
    check("grant_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic send_packet(input int src);
    for (int i = 0; i < 4; i++) begin
      en1 = (src == 1);
      en2 = (src == 2);
      check("pkt_hold", {31'b0, (src == 1) ? gnt1 : gnt2}, 32'd1);
      check("pkt_early_done", {31'b0, pkt_done}, 32'd0);
      tick();
    end
    en1 = 1'b0;
    en2 = 1'b0;
    check("pkt_done", {31'b0, pkt_done}, 32'd1);
    check("pkt_gnt_drop", {30'b0, gnt1, gnt2}, 32'd0);
  endtask

  logic [1:0] mix [6];

  initial begin
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    repeat (3) tick();
    check("rst_gnt", {30'b0, gnt1, gnt2}, 32'd0);
    check("rst_flag", {31'b0, flag}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, pkt_done}, 32'd0);
`ifdef SRC_ARB_TIMEOUT_EN
    check("rst_timeout", {31'b0, timeout}, 32'd0);
`endif
    rst = 1'b0;

    // single source: req1 in cycle 0, bytes in cycles 2-5
    req1 = 1'b1;
    check("a_c0_gnt1", {31'b0, gnt1}, 32'd0);
    tick();
    check("a_c1_gnt1", {31'b0, gnt1}, 32'd1);
    check("a_c1_flag", {31'b0, flag}, 32'd0);
    check("a_c1_busy", {31'b0, busy}, 32'd1);
    req1 = 1'b0;
    tick();
    for (int c = 2; c <= 5; c++) begin
      en1 = 1'b1;
      check("a_gnt1_held", {31'b0, gnt1}, 32'd1);
      check("a_no_done", {31'b0, pkt_done}, 32'd0);
      tick();
    end
    en1 = 1'b0;
    check("a_c6_gnt1", {31'b0, gnt1}, 32'd0);
    check("a_c6_done", {31'b0, pkt_done}, 32'd1);
    check("a_c6_busy", {31'b0, busy}, 32'd1);
    tick();
    check("a_c7_busy", {31'b0, busy}, 32'd0);
    check("a_c7_done", {31'b0, pkt_done}, 32'd0);

    // strobes in IDLE are ignored and grant nothing
    en1 = 1'b1; en2 = 1'b1;
    repeat (2) tick();
    check("idle_en_busy", {31'b0, busy}, 32'd0);
    en1 = 1'b0; en2 = 1'b0;

    // tie after reset: 1,2,1,2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req1 = 1'b1; req2 = 1'b1;
    wait_grant(1); send_packet(1);
    wait_grant(2); send_packet(2);
    wait_grant(1); send_packet(1);
    wait_grant(2); send_packet(2);
    req1 = 1'b0; req2 = 1'b0;

    // ungranted en2 traffic and early req1 drop
    req1 = 1'b1;
    wait_grant(1);
    req1 = 1'b0;
    en1 = 1'b1;
    tick();
    mix = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 6; i++) begin
      {en1, en2} = mix[i];
      check("c_gnt1_held", {31'b0, gnt1}, 32'd1);
      check("c_gnt2_low", {31'b0, gnt2}, 32'd0);
      check("c_no_done", {31'b0, pkt_done}, 32'd0);
      tick();
    end
    en1 = 1'b0; en2 = 1'b0;
    check("c_done", {31'b0, pkt_done}, 32'd1);
    check("c_gnt1_drop", {31'b0, gnt1}, 32'd0);

    // reset on the second byte of a source-2 packet
    req2 = 1'b1;
    wait_grant(2);
    req2 = 1'b0;
    en2 = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en2 = 1'b0;
    check("d_gnt", {30'b0, gnt1, gnt2}, 32'd0);
    check("d_flag", {31'b0, flag}, 32'd0);
    check("d_busy", {31'b0, busy}, 32'd0);
    check("d_done", {31'b0, pkt_done}, 32'd0);
`ifdef SRC_ARB_TIMEOUT_EN
    check("d_timeout", {31'b0, timeout}, 32'd0);
`endif
    tick();
    check("d_late_done", {31'b0, pkt_done}, 32'd0);
    req1 = 1'b1; req2 = 1'b1;
    tick();
    check("d_tie_gnt1", {31'b0, gnt1}, 32'd1);
    check("d_tie_flag", {31'b0, flag}, 32'd0);
    req1 = 1'b0; req2 = 1'b0;
    send_packet(1);

    // one byte then silence with req2 pending
    req1 = 1'b1;
    wait_grant(1);
    req1 = 1'b0; req2 = 1'b1;
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
`ifdef SRC_ARB_TIMEOUT_EN
    tick();
    check("e_idle1_gnt1", {31'b0, gnt1}, 32'd1);
    tick();
    check("e_idle2_gnt1", {31'b0, gnt1}, 32'd1);
    check("e_idle2_timeout", {31'b0, timeout}, 32'd0);
    tick();
    check("e_timeout", {31'b0, timeout}, 32'd1);
    check("e_to_gnt1", {31'b0, gnt1}, 32'd0);
    check("e_to_done", {31'b0, pkt_done}, 32'd0);
    check("e_to_busy", {31'b0, busy}, 32'd1);
    tick();
    check("e_timeout_pulse", {31'b0, timeout}, 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      check("e_gnt1_held", {31'b0, gnt1}, 32'd1);
      check("e_no_done", {31'b0, pkt_done}, 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      en1 = 1'b1;
      check("e_tail_gnt1", {31'b0, gnt1}, 32'd1);
      tick();
    end
    en1 = 1'b0;
    check("e_done", {31'b0, pkt_done}, 32'd1);
    check("e_gnt1_drop", {31'b0, gnt1}, 32'd0);
`endif
    wait_grant(2);
    req2 = 1'b0;
    send_packet(2);
    repeat (2) tick();
    check("end_busy", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
